mul_sched: RTL and testbench

In-order scheduler for the shared multiply/HILO unit in the OoO core. It holds up to DEPTH dispatched multiply-class instructions (MULT/MULTU/MUL/MADD/MSUB/MFHI/MFLO/MTHI/MTLO) in program order. It captures their operands from the CDB and sequences the multi-cycle multiplier one instruction at a time. It then presents each result to the ROB with a ready/ack handshake. HILO ordering is guaranteed by strict head-only issue.

---
 rtl/cpu_defs.sv | 32 +++
 rtl/read_operands.sv | 17 +
 rtl/mul_sched.sv | 128 ++++++++++++
 tb/tb_mul_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared core types, plus the multiply scheduler FSM state and helpers
package cpu_defs;
  typedef logic [31:0] uint32_t;
  typedef logic [63:0] uint64_t;
  typedef logic [3:0] rob_index_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } oper_t;
  typedef struct packed {
    logic       valid;
    rob_index_t reorder;
    uint32_t    value;
  } cdb_packet_t;
  typedef struct packed {
    oper_t            op;
    rob_index_t       reorder;
    logic [1:0]       rdy;
    rob_index_t [1:0] tag;
    uint32_t [1:0]    data;
  } reserve_station_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_sched_state_t;
  function automatic logic is_mf(oper_t op);
    return op inside {OP_MFHI, OP_MFLO};
  endfunction
  function automatic logic is_mt(oper_t op);
    return op inside {OP_MTHI, OP_MTLO};
  endfunction
  // MF* read HILO only, MT* need operand 0, everything else both operands
  function automatic logic operands_ready(oper_t op, logic [1:0] rdy);
    return is_mf(op) ? 1'b1 : is_mt(op) ? rdy[0] : &rdy;
  endfunction
endpackage

// File: rtl/read_operands.sv
// read_operands: captures a CDB broadcast into any waiting operand of one entry
module read_operands
  import cpu_defs::*;
(
  input  cdb_packet_t      i_cdb,
  input  reserve_station_t i_rs,
  output reserve_station_t o_rs
);
  always_comb begin
    o_rs = i_rs;
    for (int k = 0; k < 2; k++)
      if (!i_rs.rdy[k] && i_cdb.valid && i_cdb.reorder == i_rs.tag[k]) begin
        o_rs.rdy[k]  = 1'b1;
        o_rs.data[k] = i_cdb.value;
      end
  end
endmodule

// File: rtl/mul_sched.sv
// mul_sched: in-order queue that issues multiply/HILO instructions one at a time
// from the head, and hands each result to the ROB with a ready/ack handshake.
module mul_sched
  import cpu_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             rs_taken,
  input  reserve_station_t [1:0] rs_i,
  output logic [$clog2(DEPTH):0] rs_free,
  input  cdb_packet_t            cdb,
  output logic                   mul_start,
  output logic                   mul_abort,
  output oper_t                  mul_op,
  output uint32_t                mul_a,
  output uint32_t                mul_b,
  input  logic                   mul_done,
  input  uint64_t                mul_ret,
  input  uint32_t                mul_word,
  input  uint64_t                hilo_data,
  output logic                   data_ready,
  output rob_index_t             data_reorder,
  output uint32_t                result,
  input  logic                   data_ack,
  output logic                   hilo_valid,
  output uint64_t                hilo_result
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  reserve_station_t [DEPTH-1:0] r_ent, w_upd;
  reserve_station_t [1:0]       w_in;
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head, r_tail, w_tail1;
  logic [CW-1:0]    r_free, w_free;
  logic [1:0]       w_ntake;
  logic             w_pop, w_go, w_move;
  oper_t            w_op;
  mul_sched_state_t r_state, w_state;
  uint32_t          r_result;
  uint64_t          r_hilo;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    read_operands u_ro (.i_cdb(cdb), .i_rs(r_ent[i]), .o_rs(w_upd[i]));
  end
  // dispatch slots snoop the CDB too, so a same-cycle broadcast is not lost
  for (genvar i = 0; i < 2; i++) begin : g_in
    read_operands u_ro (.i_cdb(cdb), .i_rs(rs_i[i]), .o_rs(w_in[i]));
  end

  assign w_op    = r_ent[r_head].op;
  assign w_move  = is_mf(w_op) || is_mt(w_op);
  assign w_go    = r_state == IDLE && r_valid[r_head] && operands_ready(w_op, r_ent[r_head].rdy) && !flush;
  assign w_pop   = r_state == DONE && data_ack && !flush;
  assign w_ntake = {1'b0, rs_taken[0]} + {1'b0, rs_taken[1]};
  assign w_free  = r_free - CW'(w_ntake) + CW'(w_pop);
  assign w_tail1 = rs_taken[0] ? r_tail + PW'(1) : r_tail;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ent   <= '0;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_free  <= CW'(DEPTH);
    end else if (flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_free  <= CW'(DEPTH);
    end else begin
      r_ent <= w_upd;
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (rs_taken[0]) begin
        r_ent[r_tail]   <= w_in[0];
        r_valid[r_tail] <= 1'b1;
      end
      if (rs_taken[1]) begin
        r_ent[w_tail1]   <= w_in[1];
        r_valid[w_tail1] <= 1'b1;
      end
      r_tail <= r_tail + PW'(w_ntake);
      r_free <= w_free;
    end

  always @(posedge clk)
    if (rst && !flush) assert (int'(w_ntake) <= int'(r_free) + int'(w_pop));

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_state;

  always_comb
    w_state = flush ? IDLE : w_go ? (w_move ? DONE : BUSY) :
              (r_state == BUSY && mul_done) ? DONE : w_pop ? IDLE : r_state;

  always_comb begin
    mul_start    = w_go && !w_move;
    mul_abort    = flush && r_state == BUSY;
    mul_op       = w_op;
    mul_a        = r_ent[r_head].data[0];
    mul_b        = r_ent[r_head].data[1];
    data_ready   = r_state == DONE;
    data_reorder = r_ent[r_head].reorder;
    hilo_valid   = w_pop && !(is_mf(w_op) || w_op == OP_MUL);
    result       = r_result;
    hilo_result  = r_hilo;
    rs_free      = r_free;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_result <= '0;
      r_hilo   <= '0;
    end else if (w_go && w_move) begin
      r_result <= w_op == OP_MFHI ? hilo_data[63:32] : hilo_data[31:0];
      r_hilo   <= w_op == OP_MTHI ? {r_ent[r_head].data[0], hilo_data[31:0]} :
                  w_op == OP_MTLO ? {hilo_data[63:32], r_ent[r_head].data[0]} : hilo_data;
    end else if (r_state == BUSY && mul_done && !flush) begin
      r_result <= mul_word;
      r_hilo   <= mul_ret;
    end
endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed stimulus with a result scoreboard drained by an acking monitor
module tb_mul_sched;
  import cpu_defs::*;
  logic clk = 0, rst = 0, flush = 0;
  logic [1:0] rs_taken = '0;
  reserve_station_t [1:0] rs_i;
  logic [2:0] rs_free;
  cdb_packet_t cdb;
  logic mul_start, mul_abort, mul_done = 0, data_ready, data_ack = 0, hilo_valid;
  oper_t mul_op;
  uint32_t mul_a, mul_b, mul_word = '0, result;
  uint64_t mul_ret = '0, hilo_data = '0, hilo_result;
  rob_index_t data_reorder;

  always #5 clk = ~clk;

  mul_sched #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rs_taken(rs_taken), .rs_i(rs_i), .rs_free(rs_free),
    .cdb(cdb), .mul_start(mul_start), .mul_abort(mul_abort), .mul_op(mul_op), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_ret(mul_ret), .mul_word(mul_word),
    .hilo_data(hilo_data), .data_ready(data_ready), .data_reorder(data_reorder),
    .result(result), .data_ack(data_ack), .hilo_valid(hilo_valid), .hilo_result(hilo_result)
  );

  typedef struct {
    rob_index_t tag;
    uint32_t    res;
    logic       cr;
    logic       hv;
    uint64_t    hr;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  int errors = 0, checks = 0, ack_once = 0, lat = 4;
  logic ack_en = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic reserve_station_t mk(oper_t op, rob_index_t tag, uint32_t a, uint32_t b,
                                          logic [1:0] rdy, rob_index_t t1);
    mk = '0;
    mk.op = op;
    mk.reorder = tag;
    mk.rdy = rdy;
    mk.data[0] = a;
    mk.data[1] = b;
    mk.tag[0] = 4'hF;
    mk.tag[1] = t1;
  endfunction

  task automatic push(input rob_index_t t, input uint32_t r, input logic cr, input logic hv, input uint64_t hr);
    exp_t e;
    e.tag = t; e.res = r; e.cr = cr; e.hv = hv; e.hr = hr;
    sb.push_back(e);
  endtask

  task automatic disp(input logic [1:0] tk, input reserve_station_t e0, input reserve_station_t e1);
    rs_taken = tk;
    rs_i[0] = e0;
    rs_i[1] = e1;
    @(negedge clk);
    rs_taken = '0;
    cdb = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() > 0; k++) @(negedge clk);
    chk("drain_pending", 64'(sb.size()), 0);
  endtask

  // multiplier stand-in: answers every start after lat cycles, ignoring abort
  initial forever begin
    logic signed [63:0] sa, sbb;
    logic [63:0] p;
    @(negedge clk);
    #2;
    if (mul_start) begin
      sa = $signed(mul_a);
      sbb = $signed(mul_b);
      case (mul_op)
        OP_MULTU: p = {32'b0, mul_a} * {32'b0, mul_b};
        OP_MADD:  p = hilo_data + sa * sbb;
        OP_MSUB:  p = hilo_data - sa * sbb;
        default:  p = sa * sbb;
      endcase
      repeat (lat) @(negedge clk);
      #2;
      mul_ret = p;
      mul_word = p[31:0];
      mul_done = 1;
      @(negedge clk);
      #2 mul_done = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    data_ack = 1'b0;
    #1;
    if (data_ready && (ack_en || ack_once > 0)) begin
      if (ack_once > 0) ack_once--;
      data_ack = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: tag %0d presented with nothing expected", data_reorder);
      end else begin
        m_e = sb.pop_front();
        chk("data_reorder", 64'(data_reorder), 64'(m_e.tag));
        if (m_e.cr) chk("result", 64'(result), 64'(m_e.res));
        #1;
        chk("hilo_valid", 64'(hilo_valid), 64'(m_e.hv));
        if (m_e.hv) chk("hilo_result", hilo_result, m_e.hr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    rs_i = '0;
    cdb = '0;
    repeat (2) @(negedge clk);
    chk("rst_rs_free", 64'(rs_free), 4);
    chk("rst_data_ready", 64'(data_ready), 0);
    chk("rst_mul_start", 64'(mul_start), 0);
    rst = 1;
    @(negedge clk);

    push(1, 32'd15, 1, 1, 64'hF);
    disp(2'b01, mk(OP_MULT, 1, 3, 5, 2'b11, 0), '0);
    chk("mult_start_c1", 64'(mul_start), 1);
    chk("mult_operands", {mul_a, mul_b}, {32'd3, 32'd5});
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("mult_ready_c%0d", k), 64'(data_ready), 64'(k == 6));
    end
    drain();

    push(2, 32'd42, 1, 0, '0);
    cdb = '{valid: 1'b1, reorder: 4'd9, value: 32'd7};
    disp(2'b01, mk(OP_MUL, 2, 6, 0, 2'b01, 9), '0);
    chk("mul_cdb_start", 64'(mul_start), 1);
    chk("mul_cdb_b", 64'(mul_b), 7);
    drain();

    hilo_data = 64'h10;
    push(10, 32'hFFFF_FFFA, 1, 1, 64'hFFFF_FFFF_FFFF_FFFA);
    push(11, '0, 0, 1, 64'h16);
    disp(2'b11, mk(OP_MULT, 10, 32'hFFFF_FFFE, 3, 2'b11, 0), mk(OP_MADD, 11, 2, 3, 2'b11, 0));
    drain();

    hilo_data = 64'h1111_1111_2222_2222;
    push(3, '0, 0, 1, 64'hDEAD_BEEF_2222_2222);
    push(4, 32'h2222_2222, 1, 0, '0);
    disp(2'b01, mk(OP_MTHI, 3, 32'hDEAD_BEEF, 0, 2'b01, 4'hF), '0);
    chk("mthi_ready_c1", 64'(data_ready), 0);
    disp(2'b01, mk(OP_MFLO, 4, 0, 0, 2'b00, 0), '0);
    chk("mthi_ready_c2", 64'(data_ready), 1);
    drain();

    ack_en = 0;
    for (int t = 1; t <= 4; t++) push(rob_index_t'(t), 32'h2222_2222, 1, 0, '0);
    push(5, 32'h1111_1111, 1, 0, '0);
    push(6, 32'h1111_1111, 1, 0, '0);
    disp(2'b11, mk(OP_MFLO, 1, 0, 0, 2'b00, 0), mk(OP_MFLO, 2, 0, 0, 2'b00, 0));
    disp(2'b11, mk(OP_MFLO, 3, 0, 0, 2'b00, 0), mk(OP_MFLO, 4, 0, 0, 2'b00, 0));
    chk("fill_free0", 64'(rs_free), 0);
    ack_once = 1;
    @(negedge clk);
    chk("fill_free1", 64'(rs_free), 1);
    @(negedge clk);
    ack_once = 1;
    disp(2'b11, mk(OP_MFHI, 5, 0, 0, 2'b00, 0), mk(OP_MFHI, 6, 0, 0, 2'b00, 0));
    chk("wrap_free0", 64'(rs_free), 0);
    ack_en = 1;
    drain();

    lat = 6;
    disp(2'b11, mk(OP_MULT, 1, 2, 3, 2'b11, 0), mk(OP_MULT, 2, 4, 5, 2'b11, 0));
    disp(2'b01, mk(OP_MULT, 3, 6, 7, 2'b11, 0), '0);
    chk("flush_pre_free", 64'(rs_free), 1);
    flush = 1;
    #1;
    chk("flush_abort", 64'(mul_abort), 1);
    @(negedge clk);
    flush = 0;
    chk("flush_free", 64'(rs_free), 4);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1 seen |= data_ready | mul_start;
    end
    chk("flush_quiet", 64'(seen), 0);

    lat = 4;
    disp(2'b01, mk(OP_MULT, 7, 4, 4, 2'b11, 0), '0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("arst_rs_free", 64'(rs_free), 4);
    chk("arst_data_ready", 64'(data_ready), 0);
    chk("arst_mul_op", 64'(mul_op), 0);
    chk("arst_mul_ab", {mul_a, mul_b}, 0);
    chk("arst_reorder", 64'(data_reorder), 0);
    chk("arst_result", 64'(result), 0);
    chk("arst_hilo_result", hilo_result, 0);
    @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    chk("arst_late_done", 64'(data_ready), 0);
    push(8, 32'hFFFF_FFFE, 1, 1, 64'h0000_0001_FFFF_FFFE);
    disp(2'b01, mk(OP_MULTU, 8, 32'hFFFF_FFFF, 2, 2'b11, 0), '0);
    chk("arst_start_c1", 64'(mul_start), 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
